im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Write-side companion to the read-only instruction memory.
- Accepts a byte stream from a boot/debug link over a valid/ready handshake and assembles the bytes into 32-bit instruction words.
- Emits one word-write per assembled word into the instruction memory's write port, holding the CPU in reset while loading.
- Keeps a running XOR checksum so the host can confirm the image.

Parameters:
- NMEM, 128, number of 32-bit instruction-memory entries (power of two).
- AW, 7, word-address width (log2 NMEM); the byte address uses bits [AW+1:2].
- BIG_ENDIAN, 1, 1: first byte of a word goes to [31:24] (MIPS order); 0: first byte goes to [7:0].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; latches len and begins a load.
- abort  in  1  single-cycle pulse; cancels a load in progress.
- len  in  AW+1  number of words to load; sampled only when start is accepted.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- wr_en  out  1  one-cycle write strobe to instruction memory.
- wr_addr  out  32  byte address; bits [1:0]=0, bits [AW+1:2]=word index, upper bits 0.
- wr_data  out  32  assembled instruction word.
- busy  out  1  load in progress; also drives CPU hold.
- done  out  1  high while the last load completed normally.
- csum  out  32  XOR of all words written since the last accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - byte_ready, wr_en, busy and done = 0.
  - wr_addr, wr_data and csum = 0.
  - Internal byte counter and word index = 0.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE or DONE, start=1:
  - Clear csum, byte counter and word index; clear done.
  - Latch len, clamped to NMEM if larger.
  - If the latched len is 0, go to DONE with no writes; otherwise go to RECV.
- RECV:
  - byte_ready=1 and busy=1.
  - A byte is transferred on a cycle where byte_valid and byte_ready are both 1.
  - Each transfer places the byte in the lane selected by the byte counter and BIG_ENDIAN, then increments the counter modulo 4.
  - The transfer of the 4th byte moves the FSM to WRITE.
- WRITE (exactly 1 cycle):
  - wr_en=1, wr_addr={word_idx,2'b00}, wr_data=the assembled word; byte_ready=0.
  - csum <= csum ^ wr_data on this edge.
  - If word_idx == len-1, go to DONE; otherwise increment word_idx and return to RECV.
- DONE: done=1 and busy=0; the state holds until the next start.
- Latency and throughput:
  - wr_en is asserted in the cycle after the 4th byte handshake.
  - Minimum throughput is 5 cycles per word (4 byte transfers + 1 write cycle).
- Outside WRITE, wr_en=0; wr_addr and wr_data hold their last values.
- start while in RECV or WRITE is ignored.
- abort in RECV or WRITE:
  - Go to IDLE on the next edge; done=0.
  - A partial word is discarded, with no write.
  - csum keeps the value of the completed writes.
- abort has priority over a byte handshake and over the WRITE transition in the same cycle.
- abort in IDLE or DONE has no effect.
- If start and abort are asserted in the same cycle in IDLE or DONE, start wins.
- byte_valid=0 inserts stall cycles with no state change. A byte presented while byte_ready=0 is not consumed; the source must hold it.
- Word index wrap: with len clamped to NMEM, word_idx never exceeds NMEM-1. A len of NMEM writes every entry 0..NMEM-1 exactly once.
- An asynchronous reset mid-load forces all reset values; partially written memory contents are not rolled back.

Decomposition:
- Shared package/header:
  - FSM state encodings (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3).
  - The byte-address LSB constant (2).
  - The default NMEM/AW so that im_loader and the instruction memory agree.
- One sub-module is natural: im_word_assembler, which holds the byte counter and lane placement and outputs word plus word_complete.
- The FSM, word index, clamping and checksum stay in im_loader.

Test Plan:
- Reset then start with len=1; bytes 8C,01,00,04 back-to-back (BIG_ENDIAN=1) -> one wr_en pulse one cycle after the 4th byte; wr_addr=0x0, wr_data=0x8C010004; csum=0x8C010004; done=1; busy=0.
- len=3; words 0x11111111, 0x22222222, 0x44444444; byte_valid dropped for 2 cycles mid-word -> writes at addresses 0x0, 0x4, 0x8 in order; stalls are absorbed; csum=0x77777777.
- BIG_ENDIAN=0; len=1; bytes 04,00,01,8C -> wr_data=0x8C010004.
- len=200 (clamped to 128) -> exactly 128 writes; last wr_addr=0x1FC; no 129th write; done=1.
- abort after 2 bytes of word 1, with len=2 -> no write for word 1; IDLE; done=0; csum=word 0. A following start with len=0 -> done=1 next cycle, with no writes and csum=0.
- Drive rst_n low during WRITE -> wr_en falls asynchronously; all outputs return to reset values; start is ignored until rst_n is released.

Source files
------------

// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared FSM encoding and memory geometry for the instruction-memory loader.
package im_loader_pkg;
  localparam int NMEM_DEF = 128;
  localparam int AW_DEF = 7;
  localparam int ADDR_LSB = 2;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/im_word_assembler.sv
// im_word_assembler: packs four stream bytes into one 32-bit word in the selected byte order.
module im_word_assembler #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_complete
);
  logic [1:0]  cnt_q;
  logic [1:0]  lane;
  logic [31:0] word_q, word_d;
  // word reflects the incoming byte so the complete word is visible on the 4th handshake
  always_comb begin
    lane = BIG_ENDIAN ? 2'd3 - cnt_q : cnt_q;
    word_d = word_q;
    word_d[{lane, 3'b000} +: 8] = byte_data;
  end
  assign word = word_d;
  assign word_complete = take && cnt_q == 2'd3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (clr) begin
      cnt_q  <= 2'd0;
    end else if (take) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/im_loader.sv
// im_loader: loads a byte stream into instruction memory as 32-bit words, holding the CPU while busy
// and keeping an XOR checksum of every word written.
module im_loader import im_loader_pkg::*; #(
  parameter int NMEM = NMEM_DEF,
  parameter int AW = AW_DEF,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic [31:0]   csum
);
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0] len_q, len_d, len_clamp;
  logic [31:0] csum_q, csum_d, addr_q, addr_d, data_q, data_d, asm_word;
  logic accept_start, take, word_complete, last;
  assign byte_ready = state_q == S_RECV;
  assign busy = state_q == S_RECV || state_q == S_WRITE;
  assign done = state_q == S_DONE;
  // an abort in the write cycle cancels the strobe along with the checksum update
  assign wr_en = state_q == S_WRITE && !abort;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign csum = csum_q;
  assign accept_start = start && (state_q == S_IDLE || state_q == S_DONE);
  assign take = byte_valid && byte_ready && !abort;
  assign len_clamp = len > (AW+1)'(NMEM) ? (AW+1)'(NMEM) : len;
  assign last = {1'b0, idx_q} == len_q - 1'b1;
  im_word_assembler #(.BIG_ENDIAN(BIG_ENDIAN)) u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept_start || abort),
    .take(take),
    .byte_data(byte_data),
    .word(asm_word),
    .word_complete(word_complete)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    csum_d = csum_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      S_IDLE, S_DONE: if (accept_start) begin
        state_d = len_clamp == '0 ? S_DONE : S_RECV;
        idx_d = '0;
        len_d = len_clamp;
        csum_d = 32'd0;
      end
      S_RECV: if (abort) state_d = S_IDLE;
        else if (word_complete) begin
          state_d = S_WRITE;
          addr_d = 32'(idx_q) << ADDR_LSB;
          data_d = asm_word;
        end
      S_WRITE: if (abort) state_d = S_IDLE;
        else begin
          csum_d = csum_q ^ data_q;
          state_d = last ? S_DONE : S_RECV;
          idx_d = last ? idx_q : idx_q + 1'b1;
        end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      len_q <= '0;
      csum_q <= 32'd0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      csum_q <= csum_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: drives a big-endian and a little-endian loader with the same byte stream and
// scoreboards every memory write against a word/checksum model.
module tb_im_loader;
  localparam int AW = 7;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, byte_valid = 1'b0;
  logic [AW:0] len = '0;
  logic [7:0] byte_data = 8'd0;
  logic br_b, we_b, busy_b, done_b, br_l, we_l, busy_l, done_l;
  logic [31:0] wa_b, wd_b, cs_b, wa_l, wd_l, cs_l;
  int vectors = 0, miscompares = 0, widx = 0, stall_max = 0;
  logic [31:0] qa_b[$], qd_b[$], qa_l[$], qd_l[$];
  logic [31:0] csum_b = 32'd0, csum_l = 32'd0;
  always #5 clk = ~clk;
  im_loader #(.NMEM(128), .AW(AW), .BIG_ENDIAN(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(br_b),
    .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b), .busy(busy_b), .done(done_b), .csum(cs_b));
  im_loader #(.NMEM(128), .AW(AW), .BIG_ENDIAN(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(br_l),
    .wr_en(we_l), .wr_addr(wa_l), .wr_data(wd_l), .busy(busy_l), .done(done_l), .csum(cs_l));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (we_b) begin
    if (qa_b.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected write be: addr %h data %h expected no write", wa_b, wd_b);
    end else begin
      chk("wr_addr be", wa_b, qa_b.pop_front());
      chk("wr_data be", wd_b, qd_b.pop_front());
    end
  end
  always @(negedge clk) if (we_l) begin
    if (qa_l.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected write le: addr %h data %h expected no write", wa_l, wd_l);
    end else begin
      chk("wr_addr le", wa_l, qa_l.pop_front());
      chk("wr_data le", wd_l, qd_l.pop_front());
    end
  end

  task automatic check_idle_outputs(string tag);
    chk({tag, " byte_ready"}, {31'd0, br_b | br_l}, 32'd0);
    chk({tag, " wr_en"}, {31'd0, we_b | we_l}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy_b | busy_l}, 32'd0);
    chk({tag, " done"}, {31'd0, done_b | done_l}, 32'd0);
    chk({tag, " wr_addr"}, wa_b | wa_l, 32'd0);
    chk({tag, " wr_data"}, wd_b | wd_l, 32'd0);
    chk({tag, " csum"}, cs_b | cs_l, 32'd0);
  endtask

  task automatic do_start(int l);
    start = 1'b1;
    len = l[AW:0];
    @(posedge clk); #1;
    start = 1'b0;
    widx = 0; csum_b = 32'd0; csum_l = 32'd0;
  endtask

  task automatic send_byte(logic [7:0] b, bit stall);
    int t = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (!br_b && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin
      vectors++; miscompares++;
      $display("FAIL byte_ready timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
    if (stall) repeat ($urandom_range(0, stall_max)) begin @(posedge clk); #1; end
  endtask

  // w is given in stream order: first byte is w[31:24]
  task automatic send_word(logic [31:0] w, bit push);
    logic [31:0] wl = {w[7:0], w[15:8], w[23:16], w[31:24]};
    if (push) begin
      qa_b.push_back(32'(widx * 4)); qd_b.push_back(w);
      qa_l.push_back(32'(widx * 4)); qd_l.push_back(wl);
      csum_b ^= w; csum_l ^= wl;
    end
    for (int i = 0; i < 3; i++) send_byte(w[31-8*i -: 8], 1'b1);
    send_byte(w[7:0], 1'b0);
    if (push) begin
      @(negedge clk);
      chk("write latency be", {31'd0, we_b}, 32'd1);
      chk("write latency le", {31'd0, we_l}, 32'd1);
      @(posedge clk); #1;
      widx++;
    end
  endtask

  task automatic wait_done(string tag);
    int t = 0;
    while (!done_b && t < 20) begin @(posedge clk); #1; t++; end
    chk({tag, " done be"}, {31'd0, done_b}, 32'd1);
    chk({tag, " done le"}, {31'd0, done_l}, 32'd1);
    chk({tag, " busy"}, {31'd0, busy_b | busy_l}, 32'd0);
    chk({tag, " csum be"}, cs_b, csum_b);
    chk({tag, " csum le"}, cs_l, csum_l);
    chk({tag, " pending writes"}, 32'(qa_b.size() + qa_l.size()), 32'd0);
  endtask

  task automatic random_loads(int n);
    for (int r = 0; r < n; r++) begin
      int l = $urandom_range(1, 6);
      stall_max = $urandom_range(0, 3);
      do_start(l);
      for (int k = 0; k < l; k++) send_word($urandom, 1'b1);
      wait_done("random");
    end
  endtask

  initial begin
    repeat (2) @(posedge clk); #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    stall_max = 0;
    do_start(1);
    send_word(32'h8C010004, 1'b1);
    wait_done("len1");
    chk("len1 csum const", cs_b, 32'h8C010004);
    stall_max = 2;
    do_start(3);
    send_word(32'h11111111, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    send_byte(8'h22, 1'b0);
    send_byte(8'h22, 1'b0);
    qa_b.push_back(32'h4); qd_b.push_back(32'h22222222);
    qa_l.push_back(32'h4); qd_l.push_back(32'h22222222);
    csum_b ^= 32'h22222222; csum_l ^= 32'h22222222;
    @(posedge clk); #1;
    widx++;
    send_word(32'h44444444, 1'b1);
    wait_done("len3");
    chk("len3 csum const", cs_b, 32'h77777777);
    do_start(1);
    send_word(32'h0400018C, 1'b1);
    wait_done("le order");
    chk("le order wr_data", wd_l, 32'h8C010004);
    random_loads(4);
    stall_max = 0;
    do_start(200);
    for (int k = 0; k < 128; k++) send_word($urandom, 1'b1);
    wait_done("clamp");
    chk("clamp last addr", wa_b, 32'h1FC);
    chk("clamp word count", 32'(widx), 32'd128);
    repeat (5) begin @(posedge clk); #1; end
    do_start(2);
    send_word($urandom, 1'b1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", {31'd0, busy_b | busy_l}, 32'd0);
    chk("abort done", {31'd0, done_b | done_l}, 32'd0);
    chk("abort byte_ready", {31'd0, br_b | br_l}, 32'd0);
    chk("abort csum be", cs_b, csum_b);
    chk("abort csum le", cs_l, csum_l);
    repeat (3) begin @(posedge clk); #1; end
    do_start(0);
    chk("len0 done", {31'd0, done_b & done_l}, 32'd1);
    chk("len0 csum", cs_b | cs_l, 32'd0);
    chk("len0 busy", {31'd0, busy_b | busy_l}, 32'd0);
    random_loads(2);
    do_start(1);
    send_word(32'hDEADBEEF, 1'b0);
    chk("pre-reset wr_en", {31'd0, we_b & we_l}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("async reset");
    start = 1'b1;
    len = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start in reset busy", {31'd0, busy_b | busy_l}, 32'd0);
    chk("start in reset done", {31'd0, done_b | done_l}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(1);
    send_word(32'hCAFEF00D, 1'b1);
    wait_done("post reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
